vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Raster timing generator for the VGA clock display. It drives `hsync`/`vsync`, the current pixel coordinates `x_px`/`y_px`, an active-video qualifier, and line/frame strobes. The pixel renderer (font/digit lookup) and the once-per-frame button sampler consume these outputs. It runs directly on the 31.5 MHz pixel clock; clock generation (PLL) sits outside this block.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 24: horizontal front porch (pixels)
- `H_SYNC`, 40: hsync width (pixels)
- `H_BP`, 128: horizontal back porch (pixels); H_TOTAL = 832
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 9: vertical front porch (lines)
- `V_SYNC`, 3: vsync width (lines)
- `V_BP`, 28: vertical back porch (lines); V_TOTAL = 520
- `H_POL`, 0: hsync asserted level (0 = active-low)
- `V_POL`, 0: vsync asserted level (0 = active-low)
- `COORD_W`, 10: coordinate width; must satisfy 2^COORD_W ≥ max(H_TOTAL, V_TOTAL)

- `clk` in 1: pixel clock, all logic on rising edge
- `reset` in 1: synchronous, active-high reset
- `hsync` out 1: horizontal sync
- `vsync` out 1: vertical sync
- `x_px` out COORD_W: current column, 0..H_TOTAL-1
- `y_px` out COORD_W: current line, 0..V_TOTAL-1
- `activevideo` out 1: high when x_px < H_ACTIVE and y_px < V_ACTIVE
- `line_start` out 1: high when x_px == 0
- `frame_start` out 1: high when x_px == 0 and y_px == 0 (one cycle per frame)

## Operation
- One clock; reset is synchronous and active-high. While `reset` is high at a clock edge, the block loads the state for position (0,0).
- Horizontal counter:
  - Increments by 1 every cycle.
  - At H_TOTAL-1 it wraps to 0 and steps the vertical counter.
- Vertical counter:
  - Increments only on a horizontal wrap.
  - At V_TOTAL-1 with a horizontal wrap, it wraps to 0.
  - No other condition advances it.
- hsync:
  - Asserted (level H_POL) while H_ACTIVE+H_FP ≤ x_px < H_ACTIVE+H_FP+H_SYNC, i.e. x = 664..703 with defaults.
  - Otherwise at level !H_POL.
- vsync:
  - Asserted (level V_POL) for whole lines where V_ACTIVE+V_FP ≤ y_px < V_ACTIVE+V_FP+V_SYNC, i.e. y = 489..491 with defaults.
  - Changes only on the same edge as y_px.
- All outputs are registered and mutually consistent. In every cycle, hsync, vsync, activevideo, line_start and frame_start are the decode of the `x_px`/`y_px` values presented in that same cycle. The implementation decodes the next-state counter values.
- Reset values (the (0,0) decode):
  - x_px = 0, y_px = 0
  - hsync = !H_POL, vsync = !V_POL
  - activevideo = 1, line_start = 1, frame_start = 1
- Reset mid-frame: the next edge forces the (0,0) state regardless of the current position. Counting resumes from (0,0) on the first edge with `reset` low.
- Arithmetic:
  - Unsigned, COORD_W bits.
  - Wrap is by explicit compare to TOTAL-1, never by natural overflow.
  - No coordinate ever reaches TOTAL.

## Timing
- The frame is exactly H_TOTAL × V_TOTAL = 432,640 clocks. At 31.5 MHz that is ≈72.8 Hz.
- Latency from counter state to the sync/active decode: 0 cycles, since the outputs are aligned.
- After reset is released at edge N, the position advances to (1,0) at edge N+1.
- frame_start pulses are spaced exactly 432,640 cycles apart; line_start pulses exactly 832 apart.
- No handshakes; free-running.

## Structure
- Shared package `vga_timing_pkg` holds the default timing constants (H_/V_ ACTIVE, FP, SYNC, BP, TOTAL) and the polarity defaults, so the renderer and this block agree.
- One natural sub-module: `vga_axis_counter`, instantiated twice (horizontal, vertical).
  - Parameters: ACTIVE, FP, SYNC, BP, POL, W.
  - Inputs: `clk`, `reset`, `step`.
  - Outputs: `count`, `wrap`, `sync`, `active`.
  - The horizontal instance's `wrap` drives the vertical instance's `step`; the horizontal instance has `step` tied to 1.
- Elaboration check: reject any parameter set where TOTAL > 2^COORD_W or any SYNC = 0.

## Test plan
- Reset hold:
  - Stimulus: assert `reset` for 5 cycles mid-frame (e.g. at (300,250)).
  - Response: next edge shows x=0, y=0, hsync=1, vsync=1, activevideo=1, frame_start=1. The first edge after release shows (1,0), frame_start=0.
- Line wrap:
  - Response: x goes 831→0 while y goes 0→1 on the same edge, with line_start=1 at x=0.
  - Check that no coordinate ever reads 832.
- hsync window:
  - Response: hsync=1 at x=663, 0 at x=664..703, 1 at x=704, on every line.
- vsync window:
  - Response: vsync=1 for y=488, 0 for y=489..491, 1 for y=492.
  - Check that vsync transitions only at x=0.
- Active boundaries:
  - Response: activevideo=1 at (639,479), 0 at (640,0), and 0 at (0,480).
- Frame wrap and period:
  - Response: (831,519)→(0,0) with frame_start=1.
  - Consecutive frame_start pulses are 432,640 cycles apart.
  - Over 3 frames, count 3×520 hsync pulses and 3 vsync pulses.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing defaults (640x480 @ ~72.8 Hz on a 31.5 MHz pixel clock).
// The renderer and the sync generator both take their geometry from here.
package vga_timing_pkg;

   function automatic int unsigned axis_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned H_FP     = 24;
   localparam int unsigned H_SYNC   = 40;
   localparam int unsigned H_BP     = 128;
   localparam int unsigned H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);

   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_FP     = 9;
   localparam int unsigned V_SYNC   = 3;
   localparam int unsigned V_BP     = 28;
   localparam int unsigned V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam bit H_POL = 1'b0;
   localparam bit V_POL = 1'b0;

   localparam int unsigned COORD_W = 10;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster outputs of the sync generator as seen by the renderer and button sampler.
interface vga_sync_gen_if #(
   parameter int unsigned COORD_W = vga_timing_pkg::COORD_W
);
   logic               hsync;
   logic               vsync;
   logic [COORD_W-1:0] x_px;
   logic [COORD_W-1:0] y_px;
   logic               activevideo;
   logic               line_start;
   logic               frame_start;

   modport master (output hsync, vsync, x_px, y_px, activevideo, line_start, frame_start);
   modport slave  (input  hsync, vsync, x_px, y_px, activevideo, line_start, frame_start);
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with explicit wrap, plus sync/active flags
// registered from the next count so they line up with the count they describe.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned ACTIVE = 640,
   parameter int unsigned FP     = 24,
   parameter int unsigned SYNC   = 40,
   parameter int unsigned BP     = 128,
   parameter bit          POL    = 1'b0,
   parameter int unsigned W      = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         step,
   output logic [W-1:0] count,
   output logic         wrap,
   output logic         sync,
   output logic         active
);

   localparam int unsigned TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
   localparam int unsigned SYNC_START = ACTIVE + FP;
   localparam int unsigned SYNC_END   = SYNC_START + SYNC;
   localparam int unsigned CW         = W + 1;

   logic [W-1:0]  count_next_c;
   logic [CW-1:0] count_ext_c;

   // Combinational so the downstream axis steps on the very edge this one wraps.
   assign wrap = step && (count == W'(TOTAL - 1));

   // One extra bit keeps window bounds exact even when an edge equals 2^W.
   always_comb begin
      count_next_c = count;
      if (step) begin
         count_next_c = wrap ? '0 : count + W'(1);
      end
      count_ext_c = {1'b0, count_next_c};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= '0;
         sync   <= ~POL;
         active <= 1'b1;
      end else begin
         count  <= count_next_c;
         sync   <= ((count_ext_c >= CW'(SYNC_START)) && (count_ext_c < CW'(SYNC_END))) ? POL : ~POL;
         active <= (count_ext_c < CW'(ACTIVE));
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA raster timing generator: two chained axis counters plus
// registered line/frame strobes and active-video qualifier.
module vga_sync_gen #(
   parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
   parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
   parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
   parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
   parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
   parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
   parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
   parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
   parameter bit          H_POL    = vga_timing_pkg::H_POL,
   parameter bit          V_POL    = vga_timing_pkg::V_POL,
   parameter int unsigned COORD_W  = vga_timing_pkg::COORD_W
) (
   input  logic           clk,
   input  logic           reset,
   vga_sync_gen_if.master vid
);

   localparam int unsigned     H_LEN       = vga_timing_pkg::axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned     V_LEN       = vga_timing_pkg::axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam longint unsigned COORD_RANGE = 64'(1) << COORD_W;

   if ((64'(H_LEN) > COORD_RANGE) || (64'(V_LEN) > COORD_RANGE) ||
       (H_SYNC == 0) || (V_SYNC == 0)) begin : g_bad_params
      $error("vga_sync_gen: totals exceed coordinate range or a sync width is zero");
   end

   logic [COORD_W-1:0] h_count;
   logic [COORD_W-1:0] v_count;
   logic               h_wrap;
   logic               v_wrap;
   logic               h_sync;
   logic               v_sync;
   logic               h_active;
   logic               v_active;
   logic               h_active_next_c;
   logic               v_active_next_c;
   logic               activevideo_q;
   logic               line_start_q;
   logic               frame_start_q;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP),
      .POL    (H_POL),    .W  (COORD_W)
   ) u_h_axis (
      .clk    (clk),
      .reset  (reset),
      .step   (1'b1),
      .count  (h_count),
      .wrap   (h_wrap),
      .sync   (h_sync),
      .active (h_active)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP),
      .POL    (V_POL),    .W  (COORD_W)
   ) u_v_axis (
      .clk    (clk),
      .reset  (reset),
      .step   (h_wrap),
      .count  (v_count),
      .wrap   (v_wrap),
      .sync   (v_sync),
      .active (v_active)
   );

   // Predict next-cycle active flags so activevideo is a single flop aligned to x/y.
   always_comb begin
      h_active_next_c = h_wrap | (h_active & (h_count != COORD_W'(H_ACTIVE - 1)));
      v_active_next_c = v_active;
      if (h_wrap) begin
         v_active_next_c = v_wrap | (v_active & (v_count != COORD_W'(V_ACTIVE - 1)));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         activevideo_q <= 1'b1;
         line_start_q  <= 1'b1;
         frame_start_q <= 1'b1;
      end else begin
         activevideo_q <= h_active_next_c & v_active_next_c;
         line_start_q  <= h_wrap;
         frame_start_q <= h_wrap & v_wrap;
      end
   end

   assign vid.hsync       = h_sync;
   assign vid.vsync       = v_sync;
   assign vid.x_px        = h_count;
   assign vid.y_px        = v_count;
   assign vid.activevideo = activevideo_q;
   assign vid.line_start  = line_start_q;
   assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance for line-level behaviour and a
// shrunken-timing instance for frame-level behaviour, both against an arithmetic model.
module tb_vga_sync_gen;
   import vga_timing_pkg::*;

   localparam longint SH_A = 40, SH_F = 4, SH_S = 6, SH_B = 10;
   localparam longint SV_A = 30, SV_F = 3, SV_S = 2, SV_B = 5;
   localparam longint SH_T = SH_A + SH_F + SH_S + SH_B;
   localparam longint SV_T = SV_A + SV_F + SV_S + SV_B;
   localparam longint D_HT = 64'(H_TOTAL);

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       av;
      logic       ls;
      logic       fs;
   } vid_t;

   logic clk   = 1'b0;
   logic rst_d = 1'b1;
   logic rst_s = 1'b1;
   int   errors = 0;
   int   checks = 0;
   longint n_d = 0;
   longint n_s = 0;

   always #5 clk = ~clk;

   vga_sync_gen_if #(.COORD_W(10)) vid_d ();
   vga_sync_gen_if #(.COORD_W(10)) vid_s ();

   vga_sync_gen dut_d (.clk(clk), .reset(rst_d), .vid(vid_d));

   vga_sync_gen #(
      .H_ACTIVE(32'(SH_A)), .H_FP(32'(SH_F)), .H_SYNC(32'(SH_S)), .H_BP(32'(SH_B)),
      .V_ACTIVE(32'(SV_A)), .V_FP(32'(SV_F)), .V_SYNC(32'(SV_S)), .V_BP(32'(SV_B)),
      .H_POL(1'b0), .V_POL(1'b0), .COORD_W(10)
   ) dut_s (.clk(clk), .reset(rst_s), .vid(vid_s));

   // Elapsed pixel clocks since the last reset edge; position follows by division.
   always @(posedge clk) begin
      n_d <= rst_d ? 64'd0 : n_d + 64'd1;
      n_s <= rst_s ? 64'd0 : n_s + 64'd1;
   end

   function automatic vid_t ref_model(input longint n,
                                      input longint ha, input longint hf, input longint hsw, input longint hb,
                                      input longint va, input longint vf, input longint vsw, input longint vb);
      longint ht = ha + hf + hsw + hb;
      longint vt = va + vf + vsw + vb;
      longint x  = n % ht;
      longint y  = (n / ht) % vt;
      vid_t   r;
      r.x  = 10'(x);
      r.y  = 10'(y);
      r.hs = !((x >= ha + hf) && (x < ha + hf + hsw));
      r.vs = !((y >= va + vf) && (y < va + vf + vsw));
      r.av = (x < ha) && (y < va);
      r.ls = (x == 0);
      r.fs = (x == 0) && (y == 0);
      return r;
   endfunction

   function automatic vid_t exp_d();
      return ref_model(n_d, 64'(H_ACTIVE), 64'(H_FP), 64'(H_SYNC), 64'(H_BP),
                       64'(V_ACTIVE), 64'(V_FP), 64'(V_SYNC), 64'(V_BP));
   endfunction

   function automatic vid_t exp_s();
      return ref_model(n_s, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B);
   endfunction

   function automatic vid_t obs_d();
      return '{vid_d.x_px, vid_d.y_px, vid_d.hsync, vid_d.vsync,
               vid_d.activevideo, vid_d.line_start, vid_d.frame_start};
   endfunction

   function automatic vid_t obs_s();
      return '{vid_s.x_px, vid_s.y_px, vid_s.hsync, vid_s.vsync,
               vid_s.activevideo, vid_s.line_start, vid_s.frame_start};
   endfunction

   task automatic test_reset();
      vid_t o;
      vid_t rv = '{10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      rst_d = 1'b1;
      repeat (5) @(negedge clk);
      o = obs_d();
      checks++;
      if (o !== rv) begin
         errors++;
         $display("FAIL reset_state: got %h expected %h", o, rv);
      end
      rst_d = 1'b0;
      @(negedge clk);
      o = obs_d();
      checks++;
      if (o.x !== 10'd1 || o.y !== 10'd0 || o.fs !== 1'b0 || o.ls !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got x=%0d y=%0d fs=%b ls=%b expected x=1 y=0 fs=0 ls=0",
                  o.x, o.y, o.fs, o.ls);
      end
   endtask

   task automatic test_hsync_window();
      vid_t o, e, prev;
      int   low_cnt  = 0;
      int   line_cnt = 0;
      prev = obs_d();
      for (int i = 0; i < 3 * int'(D_HT) + 4; i++) begin
         @(negedge clk);
         o = obs_d();
         e = exp_d();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL default_stream: n=%0d got %h expected %h", n_d, o, e);
         end
         checks++;
         if (o.x >= 10'(H_TOTAL)) begin
            errors++;
            $display("FAIL x_range: got x=%0d expected below %0d", o.x, H_TOTAL);
         end
         if (o.hs === 1'b0) low_cnt++;
         if (prev.x == 10'(H_TOTAL - 1)) begin
            line_cnt++;
            checks++;
            if (o.x !== 10'd0 || o.y !== prev.y + 10'd1 || o.ls !== 1'b1) begin
               errors++;
               $display("FAIL line_wrap: got x=%0d y=%0d ls=%b expected x=0 y=%0d ls=1",
                        o.x, o.y, o.ls, prev.y + 10'd1);
            end
         end
         prev = o;
      end
      checks++;
      if (low_cnt != 3 * int'(H_SYNC) || line_cnt != 3) begin
         errors++;
         $display("FAIL hsync_low_cycles: got %0d over %0d wraps expected %0d over 3",
                  low_cnt, line_cnt, 3 * H_SYNC);
      end
   endtask

   task automatic test_midframe_reset();
      vid_t o;
      vid_t rv = '{10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      bit   found = 1'b0;
      rst_s = 1'b1;
      @(negedge clk);
      rst_s = 1'b0;
      for (int i = 0; i < int'(2 * SH_T * SV_T) && !found; i++) begin
         @(negedge clk);
         o = obs_s();
         if (o.x == 10'd30 && o.y == 10'd25) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL midframe_seek: position (30,25) not seen within budget");
      end
      rst_s = 1'b1;
      repeat (5) begin
         @(negedge clk);
         o = obs_s();
         checks++;
         if (o !== rv) begin
            errors++;
            $display("FAIL midframe_reset_hold: got %h expected %h", o, rv);
         end
      end
      rst_s = 1'b0;
      @(negedge clk);
      o = obs_s();
      checks++;
      if (o.x !== 10'd1 || o.y !== 10'd0 || o.fs !== 1'b0) begin
         errors++;
         $display("FAIL midframe_release: got x=%0d y=%0d fs=%b expected x=1 y=0 fs=0",
                  o.x, o.y, o.fs);
      end
   endtask

   task automatic test_random_reset();
      vid_t o, e;
      int   hold = 0;
      rst_s = 1'b1;
      @(negedge clk);
      rst_s = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         o = obs_s();
         e = exp_s();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL random_reset_stream: n=%0d got %h expected %h", n_s, o, e);
         end
         if (hold > 0) begin
            hold--;
            rst_s = 1'b1;
         end else if ($urandom_range(0, 249) == 0) begin
            hold  = int'($urandom_range(0, 4));
            rst_s = 1'b1;
         end else begin
            rst_s = 1'b0;
         end
      end
      rst_s = 1'b0;
   endtask

   task automatic test_frames();
      vid_t   o, e, prev;
      int     hs_falls = 0;
      int     vs_falls = 0;
      longint last_fs  = -1;
      longint last_ls  = -1;
      rst_s = 1'b1;
      @(negedge clk);
      rst_s = 1'b0;
      prev = obs_s();
      for (longint i = 0; i <= 3 * SH_T * SV_T; i++) begin
         o = obs_s();
         e = exp_s();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL frame_stream: n=%0d got %h expected %h", n_s, o, e);
         end
         if (i > 0) begin
            if (prev.hs === 1'b1 && o.hs === 1'b0) hs_falls++;
            if (prev.vs === 1'b1 && o.vs === 1'b0) vs_falls++;
            if (o.vs !== prev.vs) begin
               checks++;
               if (o.x !== 10'd0) begin
                  errors++;
                  $display("FAIL vsync_edge_align: got change at x=%0d expected x=0", o.x);
               end
            end
            if (prev.x == 10'(SH_T - 1) && prev.y == 10'(SV_T - 1)) begin
               checks++;
               if (o.x !== 10'd0 || o.y !== 10'd0 || o.fs !== 1'b1) begin
                  errors++;
                  $display("FAIL frame_wrap: got x=%0d y=%0d fs=%b expected x=0 y=0 fs=1",
                           o.x, o.y, o.fs);
               end
            end
         end
         if (o.fs === 1'b1) begin
            if (last_fs >= 0) begin
               checks++;
               if (i - last_fs != SH_T * SV_T) begin
                  errors++;
                  $display("FAIL frame_period: got %0d expected %0d", i - last_fs, SH_T * SV_T);
               end
            end
            last_fs = i;
         end
         if (o.ls === 1'b1) begin
            if (last_ls >= 0 && i - last_ls != SH_T) begin
               checks++;
               errors++;
               $display("FAIL line_period: got %0d expected %0d", i - last_ls, SH_T);
            end
            last_ls = i;
         end
         prev = o;
         @(negedge clk);
      end
      checks++;
      if (hs_falls != int'(3 * SV_T) || vs_falls != 3) begin
         errors++;
         $display("FAIL sync_pulse_count: got hsync=%0d vsync=%0d expected hsync=%0d vsync=3",
                  hs_falls, vs_falls, 3 * SV_T);
      end
   endtask

   initial begin
      test_reset();
      test_hsync_window();
      test_midframe_reset();
      test_random_reset();
      test_frames();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
